// File: rtl/int_mul_pkg.sv
// -----------------------------------------------------------------------------
// int_mul_pkg
// Shared definitions for the iterative integer multiplier:
//   - mul_op_e    : RISC-V multiply op encodings (match funct3[1:0])
//   - mul_state_e : sequencer states
//   - helpers     : which operands are treated as signed for a given op
// -----------------------------------------------------------------------------
package int_mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,  // low half, sign-agnostic
    MUL_OP_MULH   = 2'd1,  // high half, signed x signed
    MUL_OP_MULHSU = 2'd2,  // high half, signed x unsigned
    MUL_OP_MULHU  = 2'd3   // high half, unsigned x unsigned
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  // rs1 is signed for MULH and MULHSU.
  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  // rs2 is signed for MULH only.
  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/int_mul_step.sv
// -----------------------------------------------------------------------------
// int_mul_step
// One shift-add step: o_sum = i_acc_hi + i_a_mag * i_bits.
// The sum is XLEN+BITS_PER_CYCLE bits wide, which always holds the result
// because i_acc_hi < 2^XLEN and i_a_mag * i_bits <= (2^XLEN-1)(2^BPC-1).
// Ports:
//   i_acc_hi  XLEN            upper half of the running product
//   i_a_mag   XLEN            unsigned multiplicand magnitude
//   i_bits    BITS_PER_CYCLE  multiplier bits retired this cycle
//   o_sum     XLEN+BPC        new upper accumulator (pre-shift)
// -----------------------------------------------------------------------------
module int_mul_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [XLEN-1:0]                i_acc_hi,
  input  logic [XLEN-1:0]                i_a_mag,
  input  logic [BITS_PER_CYCLE-1:0]      i_bits,
  output logic [XLEN+BITS_PER_CYCLE-1:0] o_sum
);

  localparam int SW = XLEN + BITS_PER_CYCLE;

  // Partial products are shifted copies of |a|, one per set multiplier bit;
  // this keeps the step to a small adder tree instead of a generic multiplier.
  always_comb begin
    // NOTE: combinational outputs get a default on entry so no path leaves
    // them unassigned, which would otherwise infer a latch.
    o_sum = SW'(i_acc_hi);
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (i_bits[j]) begin
        o_sum = o_sum + (SW'(i_a_mag) << j);
      end
    end
  end

endmodule

// File: rtl/int_mul_seq.sv
// -----------------------------------------------------------------------------
// int_mul_seq
// Iterative XLEN x XLEN multiplier for MUL/MULH/MULHSU/MULHU. Operands are
// converted to unsigned magnitudes on accept, multiplied by a shift-add loop
// retiring BITS_PER_CYCLE multiplier bits per cycle, and the sign is restored
// in a final FIX cycle. Latency from accept to o_valid is XLEN/BITS_PER_CYCLE+1.
// XLEN must be >= 8 and a multiple of BITS_PER_CYCLE (1, 2 or 4).
// Ports:
//   i_clk, i_rst_n     clock (rising edge), async active-low reset
//   i_valid / o_ready  request handshake (o_ready only in IDLE)
//   i_op, i_a, i_b     op select, multiplicand rs1, multiplier rs2
//   i_flush            abort in-flight op, back to IDLE next cycle
//   o_valid / i_ready  result handshake
//   o_result           selected product half, holds last delivered value
// -----------------------------------------------------------------------------
module int_mul_seq
  import int_mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = XLEN / BPC;
  localparam int CW  = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mul_state_e        state_q,  state_d;
  mul_op_e           op_q,     op_d;
  logic              neg_q,    neg_d;
  logic [XLEN-1:0]   a_mag_q,  a_mag_d;
  logic [2*XLEN-1:0] prod_q,   prod_d;   // {accumulator, multiplier shift reg}
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  mul_op_e           op_in;
  logic              sa, sb, accept;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN+BPC-1:0] step_sum;
  logic [2*XLEN-1:0] prod_fix;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept time. -x of the most negative value wraps
  // back to 2^(XLEN-1), which is exactly its unsigned magnitude.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_in    = mul_op_e'(i_op);
    sa       = op_a_signed(op_in) & i_a[XLEN-1];
    sb       = op_b_signed(op_in) & i_b[XLEN-1];
    a_mag_in = sa ? (~i_a + XLEN'(1)) : i_a;
    b_mag_in = sb ? (~i_b + XLEN'(1)) : i_b;
    accept   = i_valid & (state_q == ST_IDLE) & ~i_flush;
    prod_fix = neg_q ? (~prod_q + (2*XLEN)'(1)) : prod_q;
  end

  int_mul_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BPC)
  ) u_step (
    .i_acc_hi (prod_q[2*XLEN-1:XLEN]),
    .i_a_mag  (a_mag_q),
    .i_bits   (prod_q[BPC-1:0]),
    .o_sum    (step_sum)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Flush overrides every other transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)             state_d = ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST)  state_d = ST_FIX;
      ST_FIX:                          state_d = ST_DONE;
      ST_DONE: if (i_ready)            state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_IDLE;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ready  = (state_q == ST_IDLE);
    o_valid  = (state_q == ST_DONE);
    o_result = result_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    a_mag_d  = a_mag_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          neg_d   = sa ^ sb;
          a_mag_d = a_mag_in;
          prod_d  = {{XLEN{1'b0}}, b_mag_in};
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        // Upper half takes the widened sum; the consumed multiplier bits
        // fall off the bottom, so the whole product shifts right by BPC.
        prod_d = {step_sum, prod_q[XLEN-1:BPC]};
        cnt_d  = cnt_q + CW'(1);
      end
      ST_FIX: begin
        // A flushed op must not disturb the last delivered result.
        if (!i_flush) begin
          result_d = (op_q == MUL_OP_MUL) ? prod_fix[XLEN-1:0]
                                          : prod_fix[2*XLEN-1:XLEN];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: these are plain datapath flops, not a memory array, so they are
      // all reset to give a deterministic o_result and clean state after reset.
      op_q     <= MUL_OP_MUL;
      neg_q    <= 1'b0;
      a_mag_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_mag_q  <= a_mag_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_int_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_int_mul_seq
// Drives two instances sharing clock/reset: the default 32-bit/1-bit-per-cycle
// configuration and a 16-bit/4-bit-per-cycle one. Directed vectors carry
// hand-computed expectations; random operands are compared against a
// sign-extended 2*XLEN product model.
// -----------------------------------------------------------------------------
module tb_int_mul_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_op = 2'd0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b1;
  logic        sel = 1'b0;       // 0 = 32-bit DUT, 1 = 16-bit DUT

  logic        rdy32, vld32, rdy16, vld16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic        m_ready, m_valid;
  logic [31:0] m_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  int_mul_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid & ~sel),
    .o_ready  (rdy32),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_valid  (vld32),
    .i_ready  (i_ready),
    .o_result (res32)
  );

  int_mul_seq #(.XLEN(16), .BITS_PER_CYCLE(4)) dut16 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid & sel),
    .o_ready  (rdy16),
    .i_op     (i_op),
    .i_a      (i_a[15:0]),
    .i_b      (i_b[15:0]),
    .i_flush  (i_flush),
    .o_valid  (vld16),
    .i_ready  (i_ready),
    .o_result (res16)
  );

  assign m_ready  = sel ? rdy16 : rdy32;
  assign m_valid  = sel ? vld16 : vld32;
  assign m_result = sel ? {16'h0, res16} : res32;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: sign/zero-extend both operands to 128 bits and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    logic [127:0] ea, eb, p;
    logic [31:0]  r;
    bit           a_s, b_s;
    a_s = (op == 2'd1) || (op == 2'd2);
    b_s = (op == 2'd1);
    ea = '0;
    eb = '0;
    for (int i = 0; i < 128; i++) begin
      ea[i] = (i < w) ? a[i] : (a_s & a[w-1]);
      eb[i] = (i < w) ? b[i] : (b_s & b[w-1]);
    end
    p = ea * eb;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = (op == 2'd0) ? p[i] : p[i+w];
    return r;
  endfunction

  // One full transaction: accept, exact latency, o_ready low while busy,
  // optional result stall with ignored i_valid pulses, handshake release.
  task automatic do_op(input bit use16, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int stall,
                       input string name);
    int lat_exp;
    int cyc;
    bit busy_ok;
    lat_exp = use16 ? 5 : 33;
    sel = use16;
    @(negedge i_clk);
    check({name, "_ready_idle"}, {31'd0, m_ready}, 32'd1);
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    i_ready = (stall == 0);
    @(posedge i_clk);                 // accept edge T
    @(negedge i_clk);
    i_valid = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    while (!m_valid && cyc < 100) begin
      if (m_ready) busy_ok = 1'b0;
      @(negedge i_clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, lat_exp);
    check({name, "_ready_busy"}, {31'd0, busy_ok}, 32'd1);
    check({name, "_result"}, m_result, exp);
    for (int s = 0; s < stall; s++) begin
      i_valid = s[0];
      @(negedge i_clk);
      check({name, "_stall_valid"}, {31'd0, m_valid}, 32'd1);
      check({name, "_stall_ready"}, {31'd0, m_ready}, 32'd0);
      check({name, "_stall_result"}, m_result, exp);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);                 // handshake edge has passed
    check({name, "_valid_drop"}, {31'd0, m_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, m_ready}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
    string       name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int seen;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul_7xm3"};
    vecs[1]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh_min_min"};
    vecs[2]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu_max_max"};
    vecs[3]  = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu_m1_max"};
    vecs[4]  = '{2'd0, 32'h12345678, 32'h00000010, 32'h23456780, 5, "mul_stall"};
    vecs[5]  = '{2'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, "mulh_7xm3"};
    vecs[6]  = '{2'd3, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 0, "mulhu_7xbig"};
    vecs[7]  = '{2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 0, "mulh_max_max"};
    vecs[8]  = '{2'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 0, "mulhsu_min"};
    vecs[9]  = '{2'd1, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 0, "mulh_min_max"};
    vecs[10] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, "mul_m1_m1"};
    vecs[11] = '{2'd3, 32'h80000000, 32'h00000002, 32'h00000001, 0, "mulhu_carry"};
    vecs[12] = '{2'd0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 0, "mul_zero"};

    // Reset state
    #12;
    check("rst_ready32",  {31'd0, rdy32}, 32'd1);
    check("rst_valid32",  {31'd0, vld32}, 32'd0);
    check("rst_result32", res32, 32'd0);
    check("rst_ready16",  {31'd0, rdy16}, 32'd1);
    check("rst_result16", {16'd0, res16}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed table, 32-bit configuration
    foreach (vecs[k]) begin
      do_op(1'b0, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].exp, vecs[k].stall, vecs[k].name);
    end

    // 16-bit / 4 bits per cycle
    do_op(1'b1, 2'd1, 32'h8000, 32'h7FFF, 32'hC000, 0, "x16_mulh_min_max");
    do_op(1'b1, 2'd0, 32'hFFFF, 32'h0003, 32'hFFFD, 2, "x16_mul_stall");

    // Flush at CALC cycle 10: back to IDLE next cycle, no result ever
    sel = 1'b0;
    do_op(1'b0, 2'd0, 32'h00000003, 32'h00000005, 32'h0000000F, 0, "pre_flush");
    @(negedge i_clk);
    i_op = 2'd0; i_a = 32'h11111111; i_b = 32'h22222222; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush_ready", {31'd0, m_ready}, 32'd1);
    check("flush_valid", {31'd0, m_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (m_valid) seen++;
    end
    check("flush_no_valid", seen, 0);
    check("flush_result_kept", m_result, 32'h0000000F);

    // Flush coinciding with i_valid in IDLE: no accept
    i_op = 2'd0; i_a = 32'h5; i_b = 32'h5; i_valid = 1'b1; i_flush = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_accept_ready", {31'd0, m_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (m_valid) seen++;
    end
    check("flush_accept_no_valid", seen, 0);
    do_op(1'b0, 2'd0, 32'h00000009, 32'h00000009, 32'h00000051, 0, "after_flush");

    // Async reset mid-CALC; o_result is 0x51 before it
    @(negedge i_clk);
    i_op = 2'd0; i_a = 32'h5; i_b = 32'h3; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (7) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid",  {31'd0, m_valid}, 32'd0);
    check("arst_ready",  {31'd0, m_ready}, 32'd1);
    check("arst_result", m_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_op(1'b0, 2'd0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 0, "arst_then_mul");

    // Random sweep against the reference model
    for (int op = 0; op < 4; op++) begin
      for (int n = 0; n < 300; n++) begin
        ra = {16'h0, 16'($urandom)};
        rb = {16'h0, 16'($urandom)};
        if (n == 0) begin ra = 32'h8000; rb = 32'h8000; end
        if (n == 1) begin ra = 32'hFFFF; rb = 32'h8000; end
        do_op(1'b1, op[1:0], ra, rb, ref_mul(op[1:0], ra, rb, 16), 0, "rnd16");
      end
      for (int n = 0; n < 25; n++) begin
        ra = $urandom;
        rb = $urandom;
        do_op(1'b0, op[1:0], ra, rb, ref_mul(op[1:0], ra, rb, 32), 0, "rnd32");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
